// File: rtl/pc_sequencer.sv
// Sequences the PC addresser: opcode fetch, then either an increment or a byte-wise 16-bit jump load.
// Define PC_SEQ_SHADOW_EN to track the expected addresser PC on shadow_pc.
module pc_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        jump_req,
  input  logic        jump_valid,
  input  logic [7:0]  jump_byte,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [4:0]  ctrl_signals,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        error,
  output logic [15:0] shadow_pc
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LDL, LDH, JWAIT_LO, JLDL, JWAIT_HI, JLDH, ERROR
  } state_t;

  state_t           state;
  logic             pending;
  logic [CNT_W-1:0] ack_cnt;

  // Control word for each state; it reaches the pins one cycle after the state,
  // so select and data_out settle a full cycle before every load bit rises.
  function automatic logic [4:0] ctrl_for(state_t s);
    case (s)
      LDL:      ctrl_for = 5'b00100;
      LDH:      ctrl_for = 5'b00010;
      JWAIT_LO: ctrl_for = 5'b00001;
      JLDL:     ctrl_for = 5'b00101;
      JWAIT_HI: ctrl_for = 5'b00001;
      JLDH:     ctrl_for = 5'b00011;
      default:  ctrl_for = 5'b00000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      ack_cnt      <= '0;
      mem_req      <= 1'b0;
      ctrl_signals <= 5'b00000;
      data_out     <= 8'h00;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      ctrl_signals <= ctrl_for(state);
      if (jump_req && state != IDLE && state != ERROR) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ack_cnt <= '0;
            mem_req <= 1'b0;
            if (halt) begin
              state   <= IDLE;
              busy    <= 1'b0;
              pending <= 1'b0;
            end else if (pending || jump_req) begin
              state   <= JWAIT_LO;
              pending <= 1'b0;
            end else begin
              state <= LDL;
            end
          end else if (ack_cnt == CNT_W'(ACK_TIMEOUT)) begin
            state   <= ERROR;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        LDL: state <= LDH;
        LDH: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        JWAIT_LO: begin
          if (jump_valid) begin
            data_out <= jump_byte;
            state    <= JLDL;
          end
        end
        JLDL: state <= JWAIT_HI;
        JWAIT_HI: begin
          if (jump_valid) begin
            data_out <= jump_byte;
            state    <= JLDH;
          end
        end
        JLDH: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        ERROR: state <= ERROR;
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_SHADOW_EN
  // Mirrors what the addresser will hold once the pending load completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_pc <= 16'h0000;
    end else begin
      case (state)
        LDH:     shadow_pc       <= shadow_pc + 16'd1;
        JLDL:    shadow_pc[7:0]  <= data_out;
        JLDH:    shadow_pc[15:8] <= data_out;
        default: shadow_pc       <= shadow_pc;
      endcase
    end
  end
`else
  assign shadow_pc = 16'h0000;
`endif

endmodule
